// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one multi-cycle external memory port between instruction fetch
//   (IF, read-only) and the MEM stage (read/write). Each access holds its
//   strobe for MEM_LATENCY cycles. The owner then gets a one-cycle ready pulse,
//   and read data is captured into that owner's rdata register.
//
//   Parameters : WORD_SIZE   data/address width
//                MEM_LATENCY strobe length per access (>= 1)
//   Ports      : clk, reset_n (async, active low)
//                if_req/if_addr -> if_rdata/if_ready         IF read port
//                mem_req/mem_we/mem_addr/mem_wdata
//                  -> mem_rdata/mem_ready                    MEM-stage port
//                readM/writeM/address/data                    memory side
//
//   Optional: define ARB_ROUND_ROBIN_EN to alternate the winner between the
//   two requesters when both are eligible. The alternation uses a last_owner
//   flop. Without the macro, MEM always has priority over IF.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_ready,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_wdata,
  output logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_ready,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  logic [0:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 readm_q, readm_d;
  logic                 writem_q, writem_d;
  logic                 if_ready_q, if_ready_d;
  logic                 mem_ready_q, mem_ready_d;
  logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_SIZE-1:0] mem_rdata_q, mem_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                 last_owner_q, last_owner_d;
`endif

  logic if_elig, mem_elig, mem_first, grant_mem;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    readm_d     = readm_q;
    writem_d    = writem_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    // A requester still seeing its ready pulse is about to drop req; a
    // held req in that cycle must not start a second access.
    if_elig  = if_req && !if_ready_q;
    mem_elig = mem_req && !mem_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
    mem_first    = (last_owner_q == OWN_IF);
`else
    mem_first    = 1'b1;
`endif
    grant_mem = mem_elig && (mem_first || !if_elig);

    case (state_q)
      IDLE: begin
        if (if_elig || mem_elig) begin
          state_d  = ACCESS;
          owner_d  = grant_mem ? OWN_MEM : OWN_IF;
          we_d     = grant_mem && mem_we;
          addr_d   = grant_mem ? mem_addr : if_addr;
          wdata_d  = grant_mem ? mem_wdata : '0;
          cnt_d    = CNT_LOAD;
          readm_d  = !we_d;
          writem_d = we_d;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = owner_d;
`endif
        end
      end
      default: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: capture read data, hand back ready, release bus.
          state_d  = IDLE;
          readm_d  = 1'b0;
          writem_d = 1'b0;
          if (owner_q == OWN_MEM) begin
            mem_ready_d = 1'b1;
            if (!we_q) mem_rdata_d = data;
          end else begin
            if_ready_d = 1'b1;
            if (!we_q) if_rdata_d = data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      readm_q     <= 1'b0;
      writem_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      readm_q     <= readm_d;
      writem_q    <= writem_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign readM     = readm_q;
  assign writeM    = writem_q;
  assign address   = addr_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  // Drive the shared bus only while a write strobe is up.
  assign data      = writem_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
//   DUT a: MEM_LATENCY=2. DUT b: MEM_LATENCY=1. Both instances share clk and
//   reset_n.
//   The memory models drive the bus with an idle pattern whenever writeM is
//   low. A DUT that releases the bus therefore reads back as that pattern.
//   Cycle numbering: inputs change on a negedge (cycle 0), and cycle k is
//   sampled on the k-th following negedge.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam logic [W-1:0] IDLE_PAT = 16'hC0DE;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic         a_if_req, a_mem_req, a_mem_we;
  logic [W-1:0] a_if_addr, a_mem_addr, a_mem_wdata;
  logic [W-1:0] a_if_rdata, a_mem_rdata, a_address;
  logic         a_if_ready, a_mem_ready, a_readM, a_writeM;
  wire  [W-1:0] a_data;
  logic [W-1:0] a_mem [0:255];

  logic         b_if_req, b_mem_req, b_mem_we;
  logic [W-1:0] b_if_addr, b_mem_addr, b_mem_wdata;
  logic [W-1:0] b_if_rdata, b_mem_rdata, b_address;
  logic         b_if_ready, b_mem_ready, b_readM, b_writeM;
  wire  [W-1:0] b_data;
  logic [W-1:0] b_mem [0:255];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(2)) u_a (
    .clk(clk), .reset_n(reset_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready),
    .readM(a_readM), .writeM(a_writeM), .address(a_address), .data(a_data));

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) u_b (
    .clk(clk), .reset_n(reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .readM(b_readM), .writeM(b_writeM), .address(b_address), .data(b_data));

  // Memory models.
  assign a_data = a_writeM ? 'z : (a_readM ? a_mem[a_address[7:0]] : IDLE_PAT);
  assign b_data = b_writeM ? 'z : (b_readM ? b_mem[b_address[7:0]] : IDLE_PAT);
  always @(posedge clk) if (a_writeM) a_mem[a_address[7:0]] <= a_data;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_if_req = 0; a_mem_req = 0; a_mem_we = 0; a_if_addr = 0; a_mem_addr = 0; a_mem_wdata = 0;
    b_if_req = 0; b_mem_req = 0; b_mem_we = 0; b_if_addr = 0; b_mem_addr = 0; b_mem_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      a_mem[i] <= '0;
      b_mem[i] <= '0;
    end
    a_mem[8'h10] <= 16'hBEEF;
    a_mem[8'h30] <= 16'hA5A5;
    a_mem[8'h50] <= 16'h0BAD;
    b_mem[8'h60] <= 16'h1111;
    b_mem[8'h61] <= 16'h2222;
    tick(); tick();

    // Reset state.
    chk("rst_readM", a_readM, 0);
    chk("rst_writeM", a_writeM, 0);
    chk("rst_address", a_address, 0);
    chk("rst_if_ready", a_if_ready, 0);
    chk("rst_mem_ready", a_mem_ready, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_mem_rdata", a_mem_rdata, 0);
    chk("rst_data", a_data, IDLE_PAT);
    chk("rst_b_readM", b_readM, 0);
    reset_n = 1'b1;

    // Simultaneous pair 1, right after reset: MEM first in both modes.
    a_if_req = 1; a_if_addr = 16'h0010;
    a_mem_req = 1; a_mem_we = 0; a_mem_addr = 16'h0030;
    tick(); chk("p1_c1_readM", a_readM, 1); chk("p1_c1_addr", a_address, 16'h0030);
    chk("p1_c1_writeM", a_writeM, 0);
    tick(); chk("p1_c2_readM", a_readM, 1);
    tick(); chk("p1_c3_mem_ready", a_mem_ready, 1); chk("p1_c3_mem_rdata", a_mem_rdata, 16'hA5A5);
    chk("p1_c3_if_ready", a_if_ready, 0); chk("p1_c3_readM", a_readM, 0);
    a_mem_req = 0;
    tick(); chk("p1_c4_readM", a_readM, 1); chk("p1_c4_addr", a_address, 16'h0010);
    chk("p1_c4_mem_ready", a_mem_ready, 0);
    tick();
    tick(); chk("p1_c6_if_ready", a_if_ready, 1); chk("p1_c6_if_rdata", a_if_rdata, 16'hBEEF);
    chk("p1_c6_readM", a_readM, 0);
    a_if_req = 0;
    tick(); chk("p1_c7_if_ready", a_if_ready, 0); chk("hold_if_rdata", a_if_rdata, 16'hBEEF);
    chk("hold_mem_rdata", a_mem_rdata, 16'hA5A5);

    // Lone MEM write 0x0020 <- 0x1234.
    a_mem_req = 1; a_mem_we = 1; a_mem_addr = 16'h0020; a_mem_wdata = 16'h1234;
    tick(); chk("wr_c1_writeM", a_writeM, 1); chk("wr_c1_readM", a_readM, 0);
    chk("wr_c1_data", a_data, 16'h1234); chk("wr_c1_addr", a_address, 16'h0020);
    tick(); chk("wr_c2_writeM", a_writeM, 1); chk("wr_c2_data", a_data, 16'h1234);
    tick(); chk("wr_c3_writeM", a_writeM, 0); chk("wr_c3_data", a_data, IDLE_PAT);
    chk("wr_c3_mem_ready", a_mem_ready, 1);
    a_mem_req = 0; a_mem_we = 0;
    tick();

    // Simultaneous pair 2 (IF read 0x0010, MEM readback of 0x0020).
    a_if_req = 1; a_if_addr = 16'h0010;
    a_mem_req = 1; a_mem_we = 0; a_mem_addr = 16'h0020;
`ifdef ARB_ROUND_ROBIN_EN
    tick(); chk("p2_c1_addr", a_address, 16'h0010);
    tick();
    tick(); chk("p2_c3_if_ready", a_if_ready, 1); chk("p2_c3_mem_ready", a_mem_ready, 0);
    a_if_req = 0;
    tick(); chk("p2_c4_addr", a_address, 16'h0020);
    tick();
    tick(); chk("p2_c6_mem_ready", a_mem_ready, 1); chk("p2_c6_mem_rdata", a_mem_rdata, 16'h1234);
    a_mem_req = 0;
`else
    tick(); chk("p2_c1_addr", a_address, 16'h0020);
    tick();
    tick(); chk("p2_c3_mem_ready", a_mem_ready, 1); chk("p2_c3_mem_rdata", a_mem_rdata, 16'h1234);
    chk("p2_c3_if_ready", a_if_ready, 0);
    a_mem_req = 0;
    tick(); chk("p2_c4_addr", a_address, 16'h0010);
    tick();
    tick(); chk("p2_c6_if_ready", a_if_ready, 1); chk("p2_c6_if_rdata", a_if_rdata, 16'hBEEF);
    a_if_req = 0;
`endif
    tick();

    // Lone IF read; a MEM write arrives mid-access and must wait.
    a_if_req = 1; a_if_addr = 16'h0010;
    tick(); chk("mid_c1_readM", a_readM, 1); chk("mid_c1_addr", a_address, 16'h0010);
    tick(); chk("mid_c2_readM", a_readM, 1);
    a_mem_req = 1; a_mem_we = 1; a_mem_addr = 16'h0040; a_mem_wdata = 16'h5555;
    tick(); chk("mid_c3_if_ready", a_if_ready, 1); chk("mid_c3_if_rdata", a_if_rdata, 16'hBEEF);
    chk("mid_c3_readM", a_readM, 0); chk("mid_c3_writeM", a_writeM, 0);
    chk("mid_c3_mem_ready", a_mem_ready, 0);
    a_if_req = 0;
    tick(); chk("mid_c4_writeM", a_writeM, 1); chk("mid_c4_addr", a_address, 16'h0040);
    chk("mid_c4_data", a_data, 16'h5555);
    a_mem_wdata = 16'h6666; a_mem_addr = 16'h0044;
    tick(); chk("mid_c5_writeM", a_writeM, 1); chk("mid_c5_addr", a_address, 16'h0040);
    chk("mid_c5_data", a_data, 16'h5555);
    tick(); chk("mid_c6_mem_ready", a_mem_ready, 1); chk("mid_c6_writeM", a_writeM, 0);
    a_mem_req = 0; a_mem_we = 0;
    tick();

    // Reset during cycle 1 of a write.
    a_mem_req = 1; a_mem_we = 1; a_mem_addr = 16'h0050; a_mem_wdata = 16'h7777;
    tick(); chk("rw_c1_writeM", a_writeM, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_abort_writeM", a_writeM, 0); chk("rw_abort_data", a_data, IDLE_PAT);
    a_mem_req = 0; a_mem_we = 0;
    tick(); chk("rw_no_mem_ready", a_mem_ready, 0); chk("rw_no_if_ready", a_if_ready, 0);
    chk("rw_writeM_low", a_writeM, 0);
    reset_n = 1'b1;
    a_if_req = 1; a_if_addr = 16'h0050;
    tick(); chk("rw_new_readM", a_readM, 1); chk("rw_new_addr", a_address, 16'h0050);
    tick();
    tick(); chk("rw_new_if_ready", a_if_ready, 1); chk("rw_new_if_rdata", a_if_rdata, 16'h0BAD);
    a_if_req = 0;
    tick();

    // MEM_LATENCY=1: MEM read then IF read, mem_req held through its ready cycle.
    b_mem_req = 1; b_mem_we = 0; b_mem_addr = 16'h0060;
    b_if_req = 1; b_if_addr = 16'h0061;
    tick(); chk("l1_c1_readM", b_readM, 1); chk("l1_c1_addr", b_address, 16'h0060);
    tick(); chk("l1_c2_readM", b_readM, 0); chk("l1_c2_mem_ready", b_mem_ready, 1);
    chk("l1_c2_mem_rdata", b_mem_rdata, 16'h1111); chk("l1_c2_if_ready", b_if_ready, 0);
    tick(); chk("l1_c3_readM", b_readM, 1); chk("l1_c3_addr", b_address, 16'h0061);
    chk("l1_c3_mem_ready", b_mem_ready, 0);
    b_mem_req = 0;
    tick(); chk("l1_c4_if_ready", b_if_ready, 1); chk("l1_c4_if_rdata", b_if_rdata, 16'h2222);
    chk("l1_c4_readM", b_readM, 0);
    b_if_req = 0;
    tick(); chk("l1_c5_readM", b_readM, 0); chk("l1_c5_mem_ready", b_mem_ready, 0);
    chk("l1_c5_if_ready", b_if_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
